// File: rtl/qed_pkg.sv
// rtl/qed_pkg.sv - shared constants and FSM encoding for the QED commit checker
package qed_pkg;
    localparam int NUM_PAIRS  = 15;
    localparam int DUP_OFFSET = 16;
    localparam int PAIR_IDX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } qed_state_e;
endpackage

// File: rtl/qed_commit_counter.sv
// rtl/qed_commit_counter.sv - saturating commit counter with sticky overflow flag
module qed_commit_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic [1:0]       inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] cnt_next_o,
    output logic             ovf_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W:0]   sum;

    always_comb begin
        sum   = {1'b0, cnt_q} + {{(CNT_W-1){1'b0}}, inc_i};
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (sum[CNT_W]) begin
            cnt_d = '1;
            ovf_d = 1'b1;
        end else begin
            cnt_d = sum[CNT_W-1:0];
        end
    end

    // Overflow stays set across ena drops; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign cnt_next_o = cnt_d;
    assign ovf_o      = ovf_q;
endmodule

// File: rtl/qed_commit_checker.sv
// rtl/qed_commit_checker.sv - commit counting and register-pair consistency scan for QED
module qed_commit_checker
    import qed_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_x,
    input  logic                  ena,
    input  logic                  com0_vld,
    input  logic                  com0_dup,
    input  logic                  com1_vld,
    input  logic                  com1_dup,
    output logic [PAIR_IDX_W-1:0] rf_raddr,
    input  logic [31:0]           rf_rdata_o,
    input  logic [31:0]           rf_rdata_d,
    output logic                  qed_ready,
    output logic                  check_busy,
    output logic                  check_done,
    output logic                  mismatch,
    output logic [PAIR_IDX_W-1:0] mismatch_idx,
    output logic                  order_err,
    output logic                  cnt_ovf
);
    localparam logic [PAIR_IDX_W-1:0] LAST_IDX = PAIR_IDX_W'(NUM_PAIRS);

    qed_state_e            state_q, state_d;
    logic [PAIR_IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]      last_chk_q, last_chk_d;
    logic                  mismatch_q, mismatch_d;
    logic [PAIR_IDX_W-1:0] mis_idx_q, mis_idx_d;
    logic                  order_err_q, order_err_d;

    logic [1:0]       inc_orig, inc_dup;
    logic [CNT_W-1:0] orig_cnt, dup_cnt, orig_next, dup_next;
    logic             orig_ovf, dup_ovf, any_vld;

    assign inc_orig = {1'b0, com0_vld & ~com0_dup} + {1'b0, com1_vld & ~com1_dup};
    assign inc_dup  = {1'b0, com0_vld &  com0_dup} + {1'b0, com1_vld &  com1_dup};
    assign any_vld  = com0_vld | com1_vld;

    qed_commit_counter #(.CNT_W(CNT_W)) u_orig_cnt (
        .clk        (clk),
        .rst_n      (reset_x),
        .clr_i      (~ena),
        .inc_i      (inc_orig),
        .cnt_o      (orig_cnt),
        .cnt_next_o (orig_next),
        .ovf_o      (orig_ovf)
    );

    qed_commit_counter #(.CNT_W(CNT_W)) u_dup_cnt (
        .clk        (clk),
        .rst_n      (reset_x),
        .clr_i      (~ena),
        .inc_i      (inc_dup),
        .cnt_o      (dup_cnt),
        .cnt_next_o (dup_next),
        .ovf_o      (dup_ovf)
    );

    assign cnt_ovf   = orig_ovf | dup_ovf;
    assign qed_ready = ena & (orig_cnt == dup_cnt) & (orig_cnt != '0) & (orig_cnt != last_chk_q);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        last_chk_d  = last_chk_q;
        mismatch_d  = mismatch_q;
        mis_idx_d   = mis_idx_q;
        order_err_d = order_err_q | (dup_next > orig_next);
        check_busy  = 1'b0;
        check_done  = 1'b0;
        rf_raddr    = '0;

        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (qed_ready && !any_vld && !cnt_ovf) begin
                    state_d = ST_SCAN;
                    idx_d   = PAIR_IDX_W'(1);
                end
            end
            ST_SCAN: begin
                check_busy = 1'b1;
                rf_raddr   = idx_q;
                // A commit invalidates the consistent point; the compare is discarded.
                if (!ena || any_vld) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else if (rf_rdata_o != rf_rdata_d) begin
                    mismatch_d = 1'b1;
                    if (!mismatch_q) begin
                        mis_idx_d = idx_q;
                    end
                    state_d = ST_DONE;
                end else if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + PAIR_IDX_W'(1);
                end
            end
            ST_DONE: begin
                check_done = 1'b1;
                last_chk_d = orig_cnt;
                state_d    = ST_IDLE;
                idx_d      = '0;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase

        if (!ena) begin
            state_d    = ST_IDLE;
            idx_d      = '0;
            last_chk_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            last_chk_q  <= '0;
            mismatch_q  <= 1'b0;
            mis_idx_q   <= '0;
            order_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            last_chk_q  <= last_chk_d;
            mismatch_q  <= mismatch_d;
            mis_idx_q   <= mis_idx_d;
            order_err_q <= order_err_d;
        end
    end

    assign mismatch     = mismatch_q;
    assign mismatch_idx = mis_idx_q;
    assign order_err    = order_err_q;
endmodule

// File: doc/qed_commit_checker.md
# qed_commit_checker

Commit-side counterpart of the QED instruction duplicator: counts committed original and duplicate instructions and detects when both streams have retired the same number of instructions. At each such consistent point it scans the architectural register file and compares every original register x1..x15 against its duplicate x17..x31, flagging the first divergence. It sits beside the commit stage and the architectural register file, observing only; it never stalls the core.

## Interface
Parameters:
- CNT_W, 16: width of the original and duplicate commit counters.

Ports:
- clk  in  1  core clock, rising edge.
- reset_x  in  1  asynchronous, active-low reset.
- ena  in  1  QED mode enable, same signal that drives the duplicator.
- com0_vld  in  1  commit slot 0 retires an instruction this cycle.
- com0_dup  in  1  slot 0 instruction is a duplicate (tag carried from the duplicator's valid output).
- com1_vld  in  1  commit slot 1 retires an instruction this cycle.
- com1_dup  in  1  slot 1 duplicate tag.
- rf_raddr  out  4  pair index i (1..15); 0 when not scanning.
- rf_rdata_o  in  32  value of register x[i], combinational from rf_raddr.
- rf_rdata_d  in  32  value of register x[i+16], combinational from rf_raddr.
- qed_ready  out  1  counters equal, nonzero, and not yet checked.
- check_busy  out  1  scan in progress.
- check_done  out  1  one-cycle pulse, full scan completed.
- mismatch  out  1  sticky, a register pair differed.
- mismatch_idx  out  4  index of first mismatching pair.
- order_err  out  1  sticky, duplicate count exceeded original count.
- cnt_ovf  out  1  sticky, a counter saturated.

## Operation
- Counters: orig_cnt += number of valid slots with dup=0; dup_cnt += number with dup=1 (0..2 each per cycle). Both held at 0 while ena=0.
- Saturation: an increment that would exceed 2^CNT_W-1 clamps to max and sets cnt_ovf; while cnt_ovf=1 no new scan starts.
- order_err set in any cycle where updated dup_cnt > updated orig_cnt.
- last_chk register holds orig_cnt at the last completed scan; cleared with counters when ena=0.
- qed_ready = ena & (orig_cnt == dup_cnt) & (orig_cnt != 0) & (orig_cnt != last_chk).
- FSM states IDLE, SCAN, DONE:
  - IDLE -> SCAN when qed_ready, no commit valid this cycle, cnt_ovf=0; idx := 1.
  - SCAN: rf_raddr = idx; if rf_rdata_o != rf_rdata_d -> set mismatch, capture idx into mismatch_idx if mismatch was 0, go DONE. Else if idx==15 -> DONE, else idx+1.
  - Any commit valid during SCAN -> abort to IDLE, no check_done, last_chk unchanged (rescan later).
  - DONE: check_done=1, last_chk := orig_cnt, -> IDLE.
  - ena=0 forces IDLE from any state in the next cycle.
- Sticky flags (mismatch, mismatch_idx, order_err, cnt_ovf) clear only on reset_x.

## Timing
- Reset: all counters, last_chk, idx 0; state IDLE; every output 0.
- Trigger sampled at edge T -> SCAN idx 1 in cycle T+1; clean pass covers idx 1..15 in T+1..T+15; check_done high in T+16.
- Mismatch at idx k: mismatch rises in cycle T+k+1, check_done in T+k+1.
- Commits in the trigger cycle block the start; commits in the same cycle as the final compare abort the scan.
- Counter updates and flag updates visible the cycle after the commit edge.
- Reset assertion mid-scan returns to IDLE asynchronously with outputs 0.

## Structure
- Package qed_pkg: NUM_PAIRS=15, DUP_OFFSET=16, PAIR_IDX_W=4, FSM state encoding.
- Sub-module qed_commit_counter (CNT_W, two increment inputs, saturating, overflow flag), instantiated twice for original and duplicate streams.
- Top module holds FSM, compare, and sticky flags.

## Test plan
- Reset then 3 originals, 3 duplicates, idle, equal registers -> qed_ready, check_busy 15 cycles, check_done at T+16, mismatch=0.
- Same but x5=0x12 and x21=0x13 -> mismatch=1, mismatch_idx=5, check_done at T+6.
- Scan started, commit on slot 1 at idx 7 -> abort, no check_done, rescan after next equal point completes normally.
- Dual commit of two duplicates with orig_cnt=1, dup_cnt=0 -> order_err=1 next cycle, stays set.
- CNT_W=4, 16 originals -> cnt_ovf=1, orig_cnt=15, no further scan starts.
- ena dropped mid-scan -> IDLE next cycle, counters 0, sticky flags retained; reset_x low clears all.
